// File: rtl/cir_peak_pkg.sv
// cir_peak_pkg
//   Shared definitions for the CIR peak / first-path detector:
//   FSM state encoding, default widths, the "no first path" marker and
//   the SC16 field positions inside a 32-bit tap word.
package cir_peak_pkg;

    // Default widths of the tap index and squared-magnitude fields.
    localparam int IDX_W_DEF = 16;
    localparam int MAG_W_DEF = 32;

    // SC16 tap layout: I in [31:16], Q in [15:0].
    localparam int SC16_W = 16;
    localparam int I_MSB  = 31;
    localparam int Q_MSB  = 15;

    // Reported in the first-path field when no tap reached the threshold.
    localparam logic [15:0] NO_FIRST = 16'hFFFF;

    // ACC   : accepting taps of a frame
    // DRAIN : one extra pipeline advance to push the last tap out of stage 1
    // EMIT0 : result word 0 (indices) offered downstream
    // EMIT1 : result word 1 (peak magnitude) offered downstream
    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        EMIT0 = 2'd2,
        EMIT1 = 2'd3
    } state_t;

endpackage

// File: rtl/cir_mag2.sv
// cir_mag2
//   Two-stage squared-magnitude pipeline for SC16 taps.
//   Stage 1 registers I*I and Q*Q, stage 2 registers their unsigned sum.
//   Both stages move only when adv is high; a valid/last sideband travels
//   alongside the data.  out_valid is high for exactly one cycle after an
//   advance that carried a real tap into stage 2, so a consumer sampling
//   out_valid sees each tap once even while the pipeline is stalled.
//
// Ports
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   adv              : advance both stages this cycle
//   in_valid         : the word on in_data is a real tap (0 for a drain bubble)
//   in_last          : the tap is the last of its frame
//   in_data[31:0]    : SC16 tap, I in [31:16], Q in [15:0]
//   out_valid        : out_mag holds a newly retired tap
//   out_last         : the retired tap was the last of its frame
//   out_mag          : I*I + Q*Q of the retired tap
module cir_mag2
    import cir_peak_pkg::*;
#(
    parameter int MAG_W = MAG_W_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             adv,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    output logic             out_last,
    output logic [MAG_W-1:0] out_mag
);

    // comp[1] = I, comp[0] = Q
    logic [1:0][SC16_W-1:0] comp;
    assign comp = {in_data[I_MSB -: SC16_W], in_data[Q_MSB -: SC16_W]};

    logic             s1_valid_reg;
    logic             s1_last_reg;
    logic             s2_valid_reg;
    logic             s2_last_reg;
    logic [MAG_W-1:0] s2_mag_reg;

    // Stage 1: one signed 16x16 square per component.  The square of a
    // 16-bit signed value is never negative and never exceeds 2^30, so the
    // 32-bit product can be carried on as unsigned.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sq
            logic signed [31:0] prod;
            logic        [31:0] sq_reg;

            assign prod = $signed(comp[gi]) * $signed(comp[gi]);

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    sq_reg <= '0;
                end else if (adv) begin
                    sq_reg <= unsigned'(prod);
                end
            end
        end
    endgenerate

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
        end else if (adv) begin
            s1_valid_reg <= in_valid;
            s1_last_reg  <= in_valid & in_last;
        end
    end

    // Stage 2: the sum of two values <= 2^30 fits in 32 bits without
    // wrapping; (-32768,-32768) lands exactly on 32'h8000_0000.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_last_reg  <= 1'b0;
            s2_mag_reg   <= '0;
        end else begin
            // Valid is a one-cycle pulse per retired tap, not a level.
            s2_valid_reg <= adv & s1_valid_reg;
            if (adv) begin
                s2_last_reg <= s1_last_reg;
                s2_mag_reg  <= MAG_W'(g_sq[0].sq_reg + g_sq[1].sq_reg);
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_last  = s2_last_reg;
    assign out_mag   = s2_mag_reg;

endmodule

// File: rtl/cir_peak_detect.sv
// cir_peak_detect
//   Consumes one CIR frame of SC16 taps (delimited by TLAST), finds the
//   strongest tap and the first tap whose squared magnitude reaches the
//   threshold, and emits a two-word result packet per frame:
//     word 0 = {peak_idx[15:0], first_idx[15:0]}   TLAST = 0
//     word 1 = peak_mag[31:0]                      TLAST = 1
//
// Ports
//   ap_clk, ap_rst_n        : clock, asynchronous active-low reset
//   i_data_TDATA/TVALID/
//   TREADY/TLAST            : AXI-Stream tap input
//   o_data_TDATA/TVALID/
//   TREADY/TLAST            : AXI-Stream result output
//   thresh                  : first-path threshold, captured on the first
//                             beat of each frame
module cir_peak_detect
    import cir_peak_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int MAG_W = MAG_W_DEF
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [31:0]      i_data_TDATA,
    input  logic             i_data_TVALID,
    output logic             i_data_TREADY,
    input  logic             i_data_TLAST,
    output logic [31:0]      o_data_TDATA,
    output logic             o_data_TVALID,
    input  logic             o_data_TREADY,
    output logic             o_data_TLAST,
    input  logic [MAG_W-1:0] thresh
);

    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    state_t state_reg, state_next;

    logic             tready_reg;
    logic             tready_next;
    logic             o_valid_reg, o_valid_next;
    logic             o_last_reg, o_last_next;
    logic [31:0]      o_data_reg, o_data_next;

    logic             in_hs;
    logic             drain;
    logic             adv;
    logic             clear;

    logic             mag_valid;
    logic             mag_last;
    logic [MAG_W-1:0] mag;

    logic             frame_open_reg;
    logic [MAG_W-1:0] thresh_reg;

    logic [IDX_W-1:0] tap_cnt_reg;
    logic [IDX_W-1:0] peak_idx_reg;
    logic [MAG_W-1:0] peak_mag_reg;
    logic [IDX_W-1:0] first_idx_reg;
    logic             found_reg;
    logic             started_reg;
    logic             done_reg;

    logic [31:0]      word0;
    logic [31:0]      word1;

    // TREADY is registered so it is low throughout reset and rises on the
    // first edge after release; it is only ever high in ACC.
    assign in_hs = i_data_TVALID & tready_reg;
    assign adv   = in_hs | drain;

    cir_mag2 #(
        .MAG_W (MAG_W)
    ) u_mag2 (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .adv       (adv),
        .in_valid  (in_hs),
        .in_last   (i_data_TLAST),
        .in_data   (i_data_TDATA),
        .out_valid (mag_valid),
        .out_last  (mag_last),
        .out_mag   (mag)
    );

    // Threshold capture: frame_open_reg is low between frames, so the beat
    // that sees it low is the first of a frame.  A one-tap frame captures
    // and closes on the same beat.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            frame_open_reg <= 1'b0;
            thresh_reg     <= '0;
        end else if (in_hs) begin
            if (!frame_open_reg) begin
                thresh_reg <= thresh;
            end
            frame_open_reg <= ~i_data_TLAST;
        end
    end

    // Peak and first-path trackers, fed by each tap retired from the
    // magnitude pipeline.  tap_cnt_reg is the index of the tap being
    // retired and saturates so very long frames report all-ones indices.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            tap_cnt_reg   <= '0;
            peak_idx_reg  <= '0;
            peak_mag_reg  <= '0;
            first_idx_reg <= '0;
            found_reg     <= 1'b0;
            started_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else if (clear) begin
            tap_cnt_reg   <= '0;
            peak_idx_reg  <= '0;
            peak_mag_reg  <= '0;
            first_idx_reg <= '0;
            found_reg     <= 1'b0;
            started_reg   <= 1'b0;
            done_reg      <= 1'b0;
        end else if (mag_valid) begin
            if (tap_cnt_reg != IDX_MAX) begin
                tap_cnt_reg <= tap_cnt_reg + 1'b1;
            end
            // Strictly greater keeps the earliest of equal peaks; the first
            // tap loads unconditionally so an all-zero frame still reports 0.
            if (!started_reg || (mag > peak_mag_reg)) begin
                peak_mag_reg <= mag;
                peak_idx_reg <= tap_cnt_reg;
            end
            started_reg <= 1'b1;
            if (!found_reg && (mag >= thresh_reg)) begin
                found_reg     <= 1'b1;
                first_idx_reg <= tap_cnt_reg;
            end
            if (mag_last) begin
                done_reg <= 1'b1;
            end
        end
    end

    assign word0 = {16'(peak_idx_reg), found_reg ? 16'(first_idx_reg) : NO_FIRST};
    assign word1 = 32'(peak_mag_reg);

    // State and registered outputs.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg   <= ACC;
            tready_reg  <= 1'b0;
            o_valid_reg <= 1'b0;
            o_last_reg  <= 1'b0;
            o_data_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            tready_reg  <= tready_next;
            o_valid_reg <= o_valid_next;
            o_last_reg  <= o_last_next;
            o_data_reg  <= o_data_next;
        end
    end

    // Next state.  In EMIT0 the output word is only loaded once the last
    // tap has left the trackers (done_reg), so word 0 never shows a
    // half-updated peak; after that it is held until accepted.
    always_comb begin
        state_next   = state_reg;
        o_valid_next = o_valid_reg;
        o_last_next  = o_last_reg;
        o_data_next  = o_data_reg;
        drain        = 1'b0;
        clear        = 1'b0;

        case (state_reg)
            ACC: begin
                if (in_hs && i_data_TLAST) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Single extra advance pushes the last tap into stage 2.
                drain      = 1'b1;
                state_next = EMIT0;
            end
            EMIT0: begin
                if (!o_valid_reg) begin
                    if (done_reg) begin
                        o_valid_next = 1'b1;
                        o_last_next  = 1'b0;
                        o_data_next  = word0;
                    end
                end else if (o_data_TREADY) begin
                    state_next  = EMIT1;
                    o_last_next = 1'b1;
                    o_data_next = word1;
                end
            end
            EMIT1: begin
                if (o_data_TREADY) begin
                    state_next   = ACC;
                    o_valid_next = 1'b0;
                    o_last_next  = 1'b0;
                    o_data_next  = '0;
                    clear        = 1'b1;
                end
            end
            default: begin
                state_next = ACC;
            end
        endcase
    end

    assign tready_next = (state_next == ACC);

    assign i_data_TREADY = tready_reg;
    assign o_data_TVALID = o_valid_reg;
    assign o_data_TLAST  = o_last_reg;
    assign o_data_TDATA  = o_data_reg;

endmodule

// File: tb/tb_cir_peak_detect.sv
// tb_cir_peak_detect
//   Directed-vector bench for cir_peak_detect.  Each frame's expected
//   result words are worked out by hand from the tap values and threshold.
module tb_cir_peak_detect;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [31:0] i_data_TDATA;
    logic        i_data_TVALID;
    logic        i_data_TREADY;
    logic        i_data_TLAST;
    logic [31:0] o_data_TDATA;
    logic        o_data_TVALID;
    logic        o_data_TREADY;
    logic        o_data_TLAST;
    logic [31:0] thresh;

    int checks = 0;
    int errors = 0;
    int in_stalls = 0;

    always #5 ap_clk = ~ap_clk;

    cir_peak_detect dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .i_data_TDATA  (i_data_TDATA),
        .i_data_TVALID (i_data_TVALID),
        .i_data_TREADY (i_data_TREADY),
        .i_data_TLAST  (i_data_TLAST),
        .o_data_TDATA  (o_data_TDATA),
        .o_data_TVALID (o_data_TVALID),
        .o_data_TREADY (o_data_TREADY),
        .o_data_TLAST  (o_data_TLAST),
        .thresh        (thresh)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic logic [31:0] tap(input int i, input int q);
        logic [31:0] iv;
        logic [31:0] qv;
        iv = i;
        qv = q;
        return {iv[15:0], qv[15:0]};
    endfunction

    // Present one beat and return 1 unit after the edge that accepted it.
    task automatic send_beat(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        i_data_TDATA  = d;
        i_data_TVALID = 1'b1;
        i_data_TLAST  = last;
        while (!i_data_TREADY && n < 200) begin
            tick();
            n++;
            in_stalls++;
        end
        if (n >= 200) check("in_ready_timeout", 32'd0, 32'd1);
        tick();
        i_data_TVALID = 1'b0;
        i_data_TLAST  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] t[$]);
        for (int k = 0; k < t.size(); k++) begin
            send_beat(t[k], k == t.size() - 1);
        end
    endtask

    // Collect one result packet with o_data_TREADY high.  Called 1 unit
    // after the TLAST handshake edge when exp_lat >= 0.
    task automatic recv(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                        input int exp_lat);
        int n;
        logic [31:0] w0;
        logic [31:0] w1;
        n = 0;
        o_data_TREADY = 1'b1;
        while (!o_data_TVALID && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check({tag, "_valid_timeout"}, 32'd0, 32'd1);
        if (exp_lat >= 0) check({tag, "_latency"}, n, exp_lat);
        w0 = o_data_TDATA;
        check({tag, "_w0"}, o_data_TDATA, e0);
        check({tag, "_w0_last"}, {31'd0, o_data_TLAST}, 32'd0);
        tick();
        w1 = o_data_TDATA;
        check({tag, "_w1_valid"}, {31'd0, o_data_TVALID}, 32'd1);
        check({tag, "_w1"}, o_data_TDATA, e1);
        check({tag, "_w1_last"}, {31'd0, o_data_TLAST}, 32'd1);
        tick();
        check({tag, "_idle_valid"}, {31'd0, o_data_TVALID}, 32'd0);
        check({tag, "_turnaround_ready"}, {31'd0, i_data_TREADY}, 32'd1);
        $display("result %s word0=%h word1=%h", tag, w0, w1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t[$];
        logic [31:0] held;
        int n;
        int viol;

        i_data_TDATA  = '0;
        i_data_TVALID = 1'b0;
        i_data_TLAST  = 1'b0;
        o_data_TREADY = 1'b1;
        thresh        = '0;

        // Reset values.
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_in_ready", {31'd0, i_data_TREADY}, 32'd0);
        check("rst_out_valid", {31'd0, o_data_TVALID}, 32'd0);
        check("rst_out_data", o_data_TDATA, 32'd0);
        check("rst_out_last", {31'd0, o_data_TLAST}, 32'd0);
        ap_rst_n = 1'b1;
        tick();
        check("rst_release_ready", {31'd0, i_data_TREADY}, 32'd1);

        // Peak and first path both at tap 5; threshold changed after the
        // first beat must not matter.
        thresh = 32'd100000;
        t = {};
        for (int k = 0; k < 8; k++) t.push_back(k == 5 ? tap(1000, -1000) : tap(10, 10));
        in_stalls = 0;
        send_beat(t[0], 1'b0);
        thresh = 32'd0;
        for (int k = 1; k < 8; k++) send_beat(t[k], k == 7);
        check("throughput_stalls", in_stalls, 32'd0);
        recv("peak5", 32'h0005_0005, 32'd2000000, 3);

        // Tie between taps 2 and 6 keeps the earlier; first path at tap 0.
        thresh = 32'd1;
        t = {};
        for (int k = 0; k < 8; k++) t.push_back((k == 2 || k == 6) ? tap(500, 0) : tap(1, 1));
        send_frame(t);
        recv("tie", {16'd2, 16'd0}, 32'd250000, 3);

        // Nothing reaches the threshold.
        thresh = 32'd1000;
        t = {tap(10, 10), tap(10, 10), tap(10, 10), tap(10, 10)};
        send_frame(t);
        recv("no_first", 32'h0000_FFFF, 32'd200, 3);

        // One-tap frame at the most negative corner.
        thresh = 32'd0;
        t = {tap(-32768, -32768)};
        send_frame(t);
        recv("one_tap", 32'h0000_0000, 32'h8000_0000, 3);

        // Output backpressure in EMIT0 with the next frame already waiting.
        o_data_TREADY = 1'b0;
        thresh = 32'd30;
        t = {tap(3, 4), tap(0, -7), tap(5, 0)};
        send_frame(t);
        n = 0;
        while (!o_data_TVALID && n < 50) begin
            tick();
            n++;
        end
        check("bp_valid_seen", {31'd0, o_data_TVALID}, 32'd1);
        held = o_data_TDATA;
        thresh = 32'd200;
        i_data_TDATA  = tap(-6, 8);
        i_data_TVALID = 1'b1;
        i_data_TLAST  = 1'b0;
        viol = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (o_data_TDATA !== held || o_data_TVALID !== 1'b1 ||
                o_data_TLAST !== 1'b0 || i_data_TREADY !== 1'b0) viol++;
        end
        check("bp_stable_cycles", viol, 32'd0);
        check("bp_held_w0", held, 32'h0001_0001);
        recv("bp", 32'h0001_0001, 32'd49, -1);
        t = {tap(-6, 8), tap(2, 0)};
        send_frame(t);
        recv("bp_next", 32'h0000_FFFF, 32'd100, 3);

        // Reset in the middle of a frame discards it.
        thresh = 32'd5;
        t = {tap(100, 0), tap(200, 0), tap(300, 0), tap(400, 0)};
        for (int k = 0; k < 4; k++) send_beat(t[k], 1'b0);
        ap_rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, i_data_TREADY}, 32'd0);
        tick();
        tick();
        ap_rst_n = 1'b1;
        viol = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (o_data_TVALID !== 1'b0) viol++;
        end
        check("midrst_no_output", viol, 32'd0);
        t = {tap(1, 1), tap(300, 0), tap(2, 2)};
        send_frame(t);
        recv("after_rst", 32'h0001_0001, 32'd90000, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
